// File: rtl/operand_issue.sv
// Issue stage in front of the 16-bit ALU: register file read with writeback bypass,
// per-register pending scoreboard for RAW/WAW hazards, and a registered operand bundle.
module operand_issue #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [2:0]       in_dst,
    input  logic [2:0]       in_srca,
    input  logic [2:0]       in_srcb,
    input  logic             in_imm_en,
    input  logic [WIDTH-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [4:0]       out_op,
    output logic [2:0]       out_dst,
    output logic             out_err,
    input  logic             wb_valid,
    input  logic [2:0]       wb_dst,
    input  logic [WIDTH-1:0] wb_data
);
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_MOD = 5'b01001;
    localparam logic [4:0] OP_LDI = 5'b01010;

    logic [WIDTH-1:0] rf [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;

    logic             wb_hit_a;
    logic             wb_hit_b;
    logic             wb_hit_d;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             op_legal;
    logic             err;
    logic             hazard;
    logic             accept;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready never depends on valid, and an offered bundle is held stable until taken.
    assign wb_hit_a = wb_valid && (wb_dst == in_srca);
    assign wb_hit_b = wb_valid && (wb_dst == in_srcb);
    assign wb_hit_d = wb_valid && (wb_dst == in_dst);

    assign opa = wb_hit_a ? wb_data : rf[in_srca];
    assign opb = in_imm_en ? in_imm : (wb_hit_b ? wb_data : rf[in_srcb]);

    // A source being written back this cycle is not a hazard: it is bypassed.
    assign hazard = ((in_op != OP_LDI) && pend[in_srca] && !wb_hit_a) ||
                    (!in_imm_en && pend[in_srcb] && !wb_hit_b) ||
                    (pend[in_dst] && !wb_hit_d);

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_legal = 1'b0;
        case (in_op) inside
            [5'd0:5'd5], [5'd7:5'd10], [5'd12:5'd17]: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    assign err = !op_legal || (((in_op == OP_DIV) || (in_op == OP_MOD)) && (opb == '0));

    // Clear before set so an issue to the register being written back stays pending.
    always_comb begin
        pend_nxt = pend;
        if (wb_valid) pend_nxt[wb_dst] = 1'b0;
        if (accept)   pend_nxt[in_dst] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_valid) begin
            rf[wb_dst] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            out_dst   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= opa;
            out_b     <= opb;
            out_op    <= in_op;
            out_dst   <= in_dst;
            out_err   <= err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
